// File: rtl/decode_stage_if.sv
// Fetch-to-execute decode bus: instruction request side plus decoded record side.
// Latency: none, wiring only.
// Backpressure: in_ready/out_ready carry valid-ready flow control in each direction.
interface decode_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [3:0]      out_type;
   logic [6:0]      out_opcode;
   logic [4:0]      out_rd;
   logic [2:0]      out_funct3;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [6:0]      out_funct7;
   logic [XLEN-1:0] out_imm;
   logic            out_illegal;

   // Fetch/execute environment view.
   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_type, out_opcode, out_rd,
             out_funct3, out_rs1, out_rs2, out_funct7, out_imm, out_illegal
   );

   // Decode stage view.
   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_type, out_opcode, out_rd,
             out_funct3, out_rs1, out_rs2, out_funct7, out_imm, out_illegal
   );
endinterface

// File: rtl/decode_stage.sv
// RV32 decode stage: classifies the instruction, extracts fields and the sign-extended immediate.
// Latency: 1 cycle from accept to head of the output buffer; no bypass on empty.
// Backpressure: DEPTH-entry FIFO; in_ready is a flop (count < DEPTH), so out_ready never reaches it combinationally.
module decode_stage #(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b0,
   parameter int DEPTH    = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   decode_stage_if.slave bus
);

   localparam logic [3:0] T_ILL   = 4'd0;
   localparam logic [3:0] T_R     = 4'd1;
   localparam logic [3:0] T_IALU  = 4'd2;
   localparam logic [3:0] T_LUI   = 4'd3;
   localparam logic [3:0] T_CSR   = 4'd4;
   localparam logic [3:0] T_B     = 4'd5;
   localparam logic [3:0] T_JAL   = 4'd6;
   localparam logic [3:0] T_JALR  = 4'd7;
   localparam logic [3:0] T_LOAD  = 4'd8;
   localparam logic [3:0] T_STORE = 4'd9;
   localparam logic [3:0] T_AUIPC = 4'd10;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [3:0]      typ;
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [6:0]      funct7;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } rec_t;

   rec_t        dec;
   logic [31:0] imm32;
   logic        legal;
   logic [31:0] w;
   logic [6:0]  f7;

   rec_t        mem_q [DEPTH];
   rec_t        mem_d [DEPTH];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        rdy_q, rdy_d;

   logic        in_ready_w;
   logic        out_valid_w;
   logic        push;
   logic        pop;
   rec_t        head;

   assign w  = bus.in_instr;
   assign f7 = w[31:25];

   // Combinational decode of the incoming word into a buffer record.
   always_comb begin
      dec         = '0;
      imm32       = '0;
      legal       = 1'b1;
      dec.pc      = bus.in_pc;
      dec.opcode  = w[6:0];
      dec.rd      = w[11:7];
      dec.funct3  = w[14:12];
      dec.rs1     = w[19:15];
      dec.rs2     = w[24:20];
      dec.funct7  = f7;
      unique case (w[6:0])
         7'b0110011: begin
            dec.typ = T_R;
            legal   = (f7 == 7'b0000000) || (f7 == 7'b0100000) ||
                      (ENABLE_M && (f7 == 7'b0000001));
         end
         7'b0010011: begin
            dec.typ = T_IALU;
            imm32   = {{20{w[31]}}, w[31:20]};
            // Shift-immediates reuse the top imm bits as funct7.
            if (w[14:12] == 3'b001 || w[14:12] == 3'b101) begin
               legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            end
         end
         7'b0110111: begin
            dec.typ = T_LUI;
            imm32   = {w[31:12], 12'b0};
         end
         7'b1110011: begin
            dec.typ = T_CSR;
            imm32   = {{20{w[31]}}, w[31:20]};
         end
         7'b1100011: begin
            dec.typ = T_B;
            imm32   = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
         end
         7'b1101111: begin
            dec.typ = T_JAL;
            imm32   = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
         end
         7'b1100111: begin
            dec.typ = T_JALR;
            imm32   = {{20{w[31]}}, w[31:20]};
         end
         7'b0000011: begin
            dec.typ = T_LOAD;
            imm32   = {{20{w[31]}}, w[31:20]};
         end
         7'b0100011: begin
            dec.typ = T_STORE;
            imm32   = {{20{w[31]}}, w[31:25], w[11:7]};
         end
         7'b0010111: begin
            dec.typ = T_AUIPC;
            imm32   = {w[31:12], 12'b0};
         end
         default: begin
            legal = 1'b0;
         end
      endcase
      // Illegal entries keep raw fields but carry no class or immediate.
      if (!legal) begin
         dec.typ     = T_ILL;
         imm32       = '0;
         dec.illegal = 1'b1;
      end
      // B and STORE have no destination register.
      if (dec.typ == T_B || dec.typ == T_STORE) begin
         dec.rd = '0;
      end
      dec.imm = XLEN'($signed(imm32));
   end

   assign in_ready_w  = rdy_q & rst_n;
   assign out_valid_w = (cnt_q != 2'd0);
   assign push        = bus.in_valid & in_ready_w;
   assign pop         = out_valid_w & bus.out_ready;

   // Next-state for FIFO storage, pointers, occupancy and registered ready; flush wins over push/pop.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      rdy_d    = rdy_q;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         cnt_d    = 2'd0;
         rdy_d    = 1'b1;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = dec;
            wr_ptr_d        = (DEPTH == 1) ? 1'b0 : ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = (DEPTH == 1) ? 1'b0 : ~rd_ptr_q;
         end
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
         endcase
         rdy_d = (cnt_d < 2'(DEPTH));
      end
   end

   // State registers with synchronous reset clearing every entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
         rdy_q    <= 1'b1;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         rdy_q    <= rdy_d;
      end
   end

   assign head            = mem_q[rd_ptr_q];
   assign bus.in_ready    = in_ready_w;
   assign bus.out_valid   = out_valid_w;
   assign bus.out_pc      = head.pc;
   assign bus.out_type    = head.typ;
   assign bus.out_opcode  = head.opcode;
   assign bus.out_rd      = head.rd;
   assign bus.out_funct3  = head.funct3;
   assign bus.out_rs1     = head.rs1;
   assign bus.out_rs2     = head.rs2;
   assign bus.out_funct7  = head.funct7;
   assign bus.out_imm     = head.imm;
   assign bus.out_illegal = head.illegal;

endmodule
